// File: rtl/hex_scan_display.sv
// Time-multiplexed 8-digit 7-segment driver for the pipeline debug word and PC.
// A per-frame snapshot keeps the display tear-free; a sticky exception flag blinks the whole display.
module hex_scan_display #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        SYS_clk_50,
    input  logic        SYS_reset,
    input  logic [31:0] DISP_value,
    input  logic [7:0]  DISP_pc,
    input  logic        DISP_mode,
    input  logic        DISP_lz_blank,
    input  logic        DISP_stall,
    input  logic        DISP_pc_invalid,
    input  logic        DISP_exception,
    input  logic        DISP_clear,
    output logic [7:0]  HEX_an,
    output logic [6:0]  HEX_seg,
    output logic        HEX_dp,
    output logic        DISP_frame
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic [FR_W-1:0]  frame_cnt;
    logic             blink_phase;
    logic             sticky;
    logic [31:0]      shadow;
    logic             mode_snap;
    logic             lz_snap;
    logic             stall_snap;
    logic             pc_invalid_snap;

    logic             tc;
    logic             frame_end;
    logic [31:0]      mapped;

    assign tc        = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_end = tc && (idx == 3'd7);
    // Mode 1 packs PC into digits 7..6; digits 5..4 carry zeros and are forced blank below.
    assign mapped    = DISP_mode ? {DISP_pc, 8'h00, DISP_value[15:0]} : DISP_value;

    always_ff @(posedge SYS_clk_50 or negedge SYS_reset) begin
        if (!SYS_reset) begin
            div_cnt     <= '0;
            idx         <= 3'd0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (tc) begin
                div_cnt <= '0;
                idx     <= idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (frame_end) begin
                if (frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge SYS_clk_50 or negedge SYS_reset) begin
        if (!SYS_reset) begin
            shadow          <= 32'h0;
            mode_snap       <= 1'b0;
            lz_snap         <= 1'b0;
            stall_snap      <= 1'b0;
            pc_invalid_snap <= 1'b0;
            DISP_frame      <= 1'b0;
        end else begin
            DISP_frame <= frame_end;
            if (frame_end) begin
                shadow          <= mapped;
                mode_snap       <= DISP_mode;
                lz_snap         <= DISP_lz_blank;
                stall_snap      <= DISP_stall;
                pc_invalid_snap <= DISP_pc_invalid;
            end
        end
    end

    // Set has priority over clear so an exception coinciding with a clear is never lost.
    always_ff @(posedge SYS_clk_50 or negedge SYS_reset) begin
        if (!SYS_reset) begin
            sticky <= 1'b0;
        end else if (DISP_exception) begin
            sticky <= 1'b1;
        end else if (DISP_clear) begin
            sticky <= 1'b0;
        end
    end

    function automatic logic [6:0] hex_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [3:0] nibble;
    logic       digit_blank;
    logic       rest_zero;
    logic       protect;
    logic       blink_now;
    logic       dp_raw;
    int         top;

    always_comb begin
        nibble    = shadow[{idx, 2'b00} +: 4];
        blink_now = sticky && blink_phase;
        // Leading zeros are judged within the digit's own group: all 8 digits, or PC (7..6) / value (3..0).
        top       = (mode_snap && idx <= 3'd3) ? 3 : 7;
        protect   = (idx == 3'd0) || (mode_snap && idx == 3'd6);
        rest_zero = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j >= int'(idx) && j <= top && shadow[4*j +: 4] != 4'h0) begin
                rest_zero = 1'b0;
            end
        end
        digit_blank = (mode_snap && (idx == 3'd4 || idx == 3'd5)) ||
                      (lz_snap && !protect && rest_zero);
        case (idx)
            3'd0:    dp_raw = ~stall_snap;
            3'd1:    dp_raw = ~pc_invalid_snap;
            default: dp_raw = 1'b1;
        endcase
    end

    // Anode stays driven for blank digits so every digit gets identical on-time.
    always_ff @(posedge SYS_clk_50 or negedge SYS_reset) begin
        if (!SYS_reset) begin
            HEX_an  <= 8'hFF;
            HEX_seg <= 7'h7F;
            HEX_dp  <= 1'b1;
        end else begin
            HEX_an  <= ~(8'b1 << idx);
            HEX_seg <= (blink_now || digit_blank) ? 7'h7F : hex_encode(nibble);
            HEX_dp  <= blink_now ? 1'b1 : dp_raw;
        end
    end

endmodule
